// File: rtl/div_unit_if.sv
// Operand/result handshake bundle for the execute-stage divider.
// master drives operands and consumes results; slave is the divider.
interface div_unit_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic             in_signed;
  logic             in_rem;
  logic             in_word;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_a, in_b, in_signed,
    output in_rem, in_word, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed,
    input  in_rem, in_word, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU and W forms.
// DIV_FAST_PATH_EN: divide-by-zero and signed overflow skip the loop.
module div_unit #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     flush,
  output logic     busy,
  div_unit_if.slave io
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int CW = $clog2(XLEN + 1);

  state_t state, state_nx;

  logic [CW-1:0]    cnt;
  logic [XLEN-1:0]  rem, quo, dvs, a_raw, res;
  logic             q_neg, r_neg, sgn, rsel, word, dz;
  logic [TAG_W-1:0] tag, otag;

  logic             accept, dz_in, fast, ge;
  logic [XLEN-1:0]  abs_a, abs_b, diff;
  logic [XLEN:0]    sh;
  logic [XLEN-1:0]  q_fin, r_fin, sel, fin;

  assign accept = (state == IDLE) & io.in_valid & ~flush;
  assign dz_in  = (io.in_b == '0);

  assign abs_a = (io.in_signed & io.in_a[XLEN-1])
               ? -io.in_a : io.in_a;
  assign abs_b = (io.in_signed & io.in_b[XLEN-1])
               ? -io.in_b : io.in_b;

`ifdef DIV_FAST_PATH_EN
  logic ovf_in;
  assign ovf_in = io.in_signed
                & (io.in_b == '1)
                & (io.in_a == {1'b1, {(XLEN-1){1'b0}}});
  assign fast = dz_in | ovf_in;
`else
  assign fast = 1'b0;
`endif

  // shift-subtract step: 65-bit compare keeps the shifted-out bit
  always_comb begin
    sh   = {rem, quo[XLEN-1]};
    ge   = (sh >= {1'b0, dvs});
    diff = sh[XLEN-1:0] - dvs;
  end

  // final sign fix-up, boundary forcing and W narrowing
  always_comb begin
    q_fin = (sgn & q_neg) ? -quo : quo;
    r_fin = (sgn & r_neg) ? -rem : rem;
    if (dz) begin
      q_fin = '1;
      r_fin = a_raw;
    end
    sel = rsel ? r_fin : q_fin;
    fin = word ? {{(XLEN-32){sel[31]}}, sel[31:0]} : sel;
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // next state and handshake outputs
  always_comb begin
    state_nx     = state;
    io.in_ready  = 1'b0;
    io.out_valid = 1'b0;
    busy         = 1'b1;
    unique case (state)
      IDLE: begin
        io.in_ready = 1'b1;
        busy        = 1'b0;
        if (accept) state_nx = BUSY;
      end
      BUSY: begin
        if (cnt == '0) state_nx = DONE;
      end
      DONE: begin
        io.out_valid = 1'b1;
        if (io.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  // operand capture, iteration and result register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      a_raw <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      sgn   <= 1'b0;
      rsel  <= 1'b0;
      word  <= 1'b0;
      dz    <= 1'b0;
      tag   <= '0;
      res   <= '0;
      otag  <= '0;
    end else if (accept) begin
      cnt   <= fast ? CW'(0) : CW'(XLEN);
      rem   <= '0;
      quo   <= fast ? io.in_a : abs_a;
      dvs   <= abs_b;
      a_raw <= io.in_a;
      q_neg <= io.in_a[XLEN-1] ^ io.in_b[XLEN-1];
      r_neg <= io.in_a[XLEN-1];
      sgn   <= io.in_signed;
      rsel  <= io.in_rem;
      word  <= io.in_word;
      dz    <= dz_in;
      tag   <= io.in_tag;
    end else if (state == BUSY && !flush) begin
      if (cnt != '0) begin
        rem <= ge ? diff : sh[XLEN-1:0];
        quo <= {quo[XLEN-2:0], ge};
        cnt <= cnt - 1'b1;
      end else begin
        res  <= fin;
        otag <= tag;
      end
    end
  end

  assign io.out_result = res;
  assign io.out_tag    = otag;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: results, latency, stall,
// flush and async reset behaviour.
module tb_div_unit;

  localparam int XLEN  = 64;
  localparam int TAG_W = 5;

`ifdef DIV_FAST_PATH_EN
  localparam int ZL = 1;
`else
  localparam int ZL = 65;
`endif

  logic clk;
  logic reset;
  logic flush;
  logic busy;

  int checks = 0;
  int errors = 0;

  div_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  div_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .busy  (busy),
    .io    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", nm, obs, exp);
    end
  endtask

  task automatic issue(input logic [63:0] a,
                       input logic [63:0] b,
                       input logic sg, input logic rm,
                       input logic wd,
                       input logic [4:0] tg);
    @(negedge clk);
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_signed = sg;
    bus.in_rem    = rm;
    bus.in_word   = wd;
    bus.in_tag    = tg;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output bit rdy);
    lat = 0;
    rdy = 1'b0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.in_ready) rdy = 1'b1;
    end
  endtask

  task automatic run(input string nm,
                     input logic [63:0] a,
                     input logic [63:0] b,
                     input logic sg, input logic rm,
                     input logic wd,
                     input logic [4:0] tg,
                     input logic [63:0] exp,
                     input int exp_lat);
    int lat;
    bit rdy;
    bus.out_ready = 1'b1;
    issue(a, b, sg, rm, wd, tg);
    wait_valid(lat, rdy);
    chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
    chk({nm, " result"}, bus.out_result, exp);
    chk({nm, " tag"}, 64'(bus.out_tag), 64'(tg));
    chk({nm, " in_ready low"}, 64'(rdy), 64'd0);
    @(posedge clk);
    #1;
    chk({nm, " back idle"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    int lat;
    bit rdy;
    bit seen;

    reset         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_signed = 1'b0;
    bus.in_rem    = 1'b0;
    bus.in_word   = 1'b0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst out_result", bus.out_result, 64'd0);
    chk("rst out_tag", 64'(bus.out_tag), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    run("div -7/2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
        1'b1, 1'b0, 1'b0, 5'd3,
        64'hFFFF_FFFF_FFFF_FFFD, 65);
    run("remu max/10", 64'hFFFF_FFFF_FFFF_FFFF, 64'd10,
        1'b0, 1'b1, 1'b0, 5'd4, 64'd5, 65);
    run("divu max/10", 64'hFFFF_FFFF_FFFF_FFFF, 64'd10,
        1'b0, 1'b0, 1'b0, 5'd5,
        64'h1999_9999_9999_9999, 65);
    run("divw ovf", 64'hFFFF_FFFF_8000_0000,
        64'hFFFF_FFFF_FFFF_FFFF,
        1'b1, 1'b0, 1'b1, 5'd6,
        64'hFFFF_FFFF_8000_0000, 65);
    run("remw ovf", 64'hFFFF_FFFF_8000_0000,
        64'hFFFF_FFFF_FFFF_FFFF,
        1'b1, 1'b1, 1'b1, 5'd7, 64'd0, 65);
    run("div by 0", 64'd123, 64'd0,
        1'b1, 1'b0, 1'b0, 5'd8,
        64'hFFFF_FFFF_FFFF_FFFF, ZL);
    run("rem by 0", 64'd123, 64'd0,
        1'b1, 1'b1, 1'b0, 5'd9, 64'd123, ZL);
    run("div neg by 0", 64'hFFFF_FFFF_FFFF_FFF9, 64'd0,
        1'b1, 1'b0, 1'b0, 5'd10,
        64'hFFFF_FFFF_FFFF_FFFF, ZL);
    run("div ovf64", 64'h8000_0000_0000_0000,
        64'hFFFF_FFFF_FFFF_FFFF,
        1'b1, 1'b0, 1'b0, 5'd11,
        64'h8000_0000_0000_0000, ZL);
    run("rem ovf64", 64'h8000_0000_0000_0000,
        64'hFFFF_FFFF_FFFF_FFFF,
        1'b1, 1'b1, 1'b0, 5'd12, 64'd0, ZL);

    // consumer stalls for 10 cycles: 100 / -7 = -14
    bus.out_ready = 1'b0;
    issue(64'd100, 64'hFFFF_FFFF_FFFF_FFF9,
          1'b1, 1'b0, 1'b0, 5'd21);
    wait_valid(lat, rdy);
    chk("stall latency", 64'(lat), 64'd65);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("stall valid", 64'(bus.out_valid), 64'd1);
      chk("stall result", bus.out_result,
          64'hFFFF_FFFF_FFFF_FFF2);
      chk("stall tag", 64'(bus.out_tag), 64'd21);
      chk("stall in_ready", 64'(bus.in_ready), 64'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall release", 64'(bus.in_ready), 64'd1);
    chk("stall valid drop", 64'(bus.out_valid), 64'd0);

    // flush at iteration 30
    issue(64'd1000, 64'd3, 1'b0, 1'b0, 1'b0, 5'd13);
    repeat (29) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    chk("flush busy", 64'(busy), 64'd0);
    chk("flush in_ready", 64'(bus.in_ready), 64'd1);
    chk("flush out_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("flush no result", 64'(seen), 64'd0);
    run("divu 100/7", 64'd100, 64'd7,
        1'b0, 1'b0, 1'b0, 5'd14, 64'd14, 65);

    // flush together with in_valid: nothing accepted
    @(negedge clk);
    bus.in_a     = 64'd50;
    bus.in_b     = 64'd5;
    bus.in_valid = 1'b1;
    flush        = 1'b1;
    @(posedge clk);
    #1;
    chk("flush+valid busy", 64'(busy), 64'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    flush        = 1'b0;

    // flush while DONE with out_ready high
    bus.out_ready = 1'b0;
    issue(64'd50, 64'd5, 1'b0, 1'b0, 1'b0, 5'd15);
    wait_valid(lat, rdy);
    chk("flush done valid", 64'(bus.out_valid), 64'd1);
    @(negedge clk);
    bus.out_ready = 1'b1;
    flush         = 1'b1;
    @(posedge clk);
    #1;
    chk("flush done idle", 64'(busy), 64'd0);
    @(negedge clk);
    flush = 1'b0;

    // async reset mid-operation
    issue(64'd999, 64'd4, 1'b0, 1'b0, 1'b0, 5'd16);
    repeat (20) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid rst busy", 64'(busy), 64'd0);
    chk("mid rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid rst result", bus.out_result, 64'd0);
    chk("mid rst tag", 64'(bus.out_tag), 64'd0);
    chk("mid rst in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b1;

    run("post rst rem", 64'd999, 64'd4,
        1'b0, 1'b1, 1'b0, 5'd17, 64'd3, 65);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
